// File: rtl/bip_pkg.sv
// Purpose: shared constants for the BIP control unit (widths, opcodes, mux codes, FSM states).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bip_pkg;

    localparam int PC_W    = 11;
    localparam int OPC_W   = 5;
    localparam int OPER_W  = 11;
    localparam int INSTR_W = OPC_W + OPER_W;

    // Opcodes, Instr[15:11]
    localparam logic [OPC_W-1:0] OPC_HLT  = 5'b00000;
    localparam logic [OPC_W-1:0] OPC_STO  = 5'b00001;
    localparam logic [OPC_W-1:0] OPC_LD   = 5'b00010;
    localparam logic [OPC_W-1:0] OPC_LDI  = 5'b00011;
    localparam logic [OPC_W-1:0] OPC_ADD  = 5'b00100;
    localparam logic [OPC_W-1:0] OPC_ADDI = 5'b00101;
    localparam logic [OPC_W-1:0] OPC_SUB  = 5'b00110;
    localparam logic [OPC_W-1:0] OPC_SUBI = 5'b00111;

    // Accumulator input mux
    localparam logic [1:0] SELA_RAM = 2'd0;
    localparam logic [1:0] SELA_IMM = 2'd1;
    localparam logic [1:0] SELA_BAU = 2'd2;

    // Add/sub B operand mux
    localparam logic SELB_RAM = 1'b0;
    localparam logic SELB_IMM = 1'b1;

    // Add/sub control
    localparam logic OP_SUB = 1'b0;
    localparam logic OP_ADD = 1'b1;

    // FSM states; code 2'd3 is unused and recovers to FETCH
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

endpackage

// File: rtl/bip_pc.sv
// Purpose: program counter register, increments by one when inc_en is high, wraps silently.
// Latency: pc updates on the rising edge after inc_en; async active-low reset to 0.
// Backpressure: none; inc_en low holds the value.
// Ports: clk, rst_n, inc_en in; pc out (PC_W).
module bip_pc
    import bip_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            inc_en,
    output logic [PC_W-1:0] pc
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;

    // Natural PC_W-bit overflow gives the wrap from all-ones to 0
    always_comb begin
        pc_d = pc_q;
        if (inc_en) begin
            pc_d = pc_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/bip_control.sv
// Purpose: BIP multi-cycle control unit: FETCH latches Instr into IR and bumps PC, EXEC decodes IR into datapath controls.
// Latency: enables assert in the cycle after Instr is sampled; CPI 2; HLT parks in HALT until reset.
// Backpressure: none; program memory must present Instr during FETCH.
// Ports: Clk, Rst_n, Instr in; PC, Operand, SelA, SelB, WrAcc, Op, WrRam, RdRam, Halted out.
module bip_control
    import bip_pkg::*;
(
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic [INSTR_W-1:0] Instr,
    output logic [PC_W-1:0]    PC,
    output logic [OPER_W-1:0]  Operand,
    output logic [1:0]         SelA,
    output logic               SelB,
    output logic               WrAcc,
    output logic               Op,
    output logic               WrRam,
    output logic               RdRam,
    output logic               Halted
);

    state_t             state_q;
    state_t             state_d;
    logic [INSTR_W-1:0] ir_q;
    logic [INSTR_W-1:0] ir_d;
    logic [OPC_W-1:0]   opcode;

    assign opcode  = ir_q[INSTR_W-1:OPER_W];
    assign Operand = ir_q[OPER_W-1:0];

    bip_pc u_pc (
        .clk    (Clk),
        .rst_n  (Rst_n),
        .inc_en (state_q == ST_FETCH),
        .pc     (PC)
    );

    always_comb begin
        state_d = ST_FETCH;
        ir_d    = ir_q;
        case (state_q)
            ST_FETCH: begin
                ir_d    = Instr;
                state_d = ST_EXEC;
            end
            ST_EXEC:  state_d = (opcode == OPC_HLT) ? ST_HALT : ST_FETCH;
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= ST_FETCH;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // Decode depends only on flops that reset asynchronously, so every
    // enable drops the moment Rst_n falls, even mid-EXEC.
    always_comb begin
        SelA  = SELA_RAM;
        SelB  = SELB_RAM;
        Op    = OP_SUB;
        WrAcc = 1'b0;
        WrRam = 1'b0;
        RdRam = 1'b0;
        if (state_q == ST_EXEC) begin
            case (opcode)
                OPC_STO:  WrRam = 1'b1;
                OPC_LD:   begin RdRam = 1'b1; SelA = SELA_RAM; WrAcc = 1'b1; end
                OPC_LDI:  begin SelA = SELA_IMM; WrAcc = 1'b1; end
                OPC_ADD:  begin RdRam = 1'b1; SelB = SELB_RAM; Op = OP_ADD; SelA = SELA_BAU; WrAcc = 1'b1; end
                OPC_ADDI: begin SelB = SELB_IMM; Op = OP_ADD; SelA = SELA_BAU; WrAcc = 1'b1; end
                OPC_SUB:  begin RdRam = 1'b1; SelB = SELB_RAM; Op = OP_SUB; SelA = SELA_BAU; WrAcc = 1'b1; end
                OPC_SUBI: begin SelB = SELB_IMM; Op = OP_SUB; SelA = SELA_BAU; WrAcc = 1'b1; end
                default:  ; // HLT and undefined opcodes: no enables
            endcase
        end
    end

    assign Halted = (state_q == ST_HALT);

endmodule

// File: tb/tb_bip_control.sv
module tb_bip_control;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic [15:0] Instr;
    logic [10:0] PC;
    logic [10:0] Operand;
    logic [1:0]  SelA;
    logic        SelB;
    logic        WrAcc;
    logic        Op;
    logic        WrRam;
    logic        RdRam;
    logic        Halted;

    bip_control dut (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .Instr   (Instr),
        .PC      (PC),
        .Operand (Operand),
        .SelA    (SelA),
        .SelB    (SelB),
        .WrAcc   (WrAcc),
        .Op      (Op),
        .WrRam   (WrRam),
        .RdRam   (RdRam),
        .Halted  (Halted)
    );

    always #5 Clk = ~Clk;

    int n_cmp  = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: which phase of its two-cycle instruction the core is in,
    // the last instruction fetched and the program counter as a plain integer.
    int          m_pc;
    logic [15:0] m_ir;
    int          m_phase; // 0 fetching, 1 executing, 2 halted

    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            m_pc    <= 0;
            m_ir    <= 16'h0000;
            m_phase <= 0;
        end else if (m_phase == 0) begin
            m_ir    <= Instr;
            m_pc    <= (m_pc + 1) % 2048;
            m_phase <= 1;
        end else if (m_phase == 1) begin
            m_phase <= (m_ir[15:11] == 5'd0) ? 2 : 0;
        end
    end

    // Expected control word from the decode table: {SelA, SelB, WrAcc, Op, WrRam, RdRam}
    function automatic logic [6:0] table_ctl(input logic [4:0] opc);
        case (opc)
            5'd1:    return {2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
            5'd2:    return {2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
            5'd3:    return {2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
            5'd4:    return {2'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
            5'd5:    return {2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
            5'd6:    return {2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
            5'd7:    return {2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
            default: return 7'd0;
        endcase
    endfunction

    // Single compare process: every falling edge, all outputs against the model.
    always @(negedge Clk) begin
        if (cmp_en) begin
            logic [6:0]  ctl;
            logic [29:0] exp_v;
            logic [29:0] act_v;
            ctl   = (m_phase == 1) ? table_ctl(m_ir[15:11]) : 7'd0;
            exp_v = {11'(m_pc), m_ir[10:0], ctl, (m_phase == 2)};
            act_v = {PC, Operand, SelA, SelB, WrAcc, Op, WrRam, RdRam, Halted};
            chk("cycle_outputs", 32'(act_v), 32'(exp_v));
            chk("wr_exclusive", 32'(WrRam & WrAcc), 32'd0);
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Called at a FETCH drive point; returns at the EXEC drive point.
    task automatic run_instr(input logic [15:0] ins);
        Instr = ins;
        step();
        Instr = 16'($urandom);
    endtask

    function automatic logic [15:0] rand_no_hlt();
        logic [4:0]  opc;
        logic [10:0] opr;
        opc = 5'($urandom_range(1, 31));
        opr = 11'($urandom);
        return {opc, opr};
    endfunction

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        int halt_cnt;
        Rst_n = 1'b0;
        Instr = 16'h0000;
        step();
        cmp_en = 1'b1;
        step();
        chk("reset_pc", 32'(PC), 32'd0);
        chk("reset_ctl", 32'({SelA, SelB, WrAcc, Op, WrRam, RdRam, Halted}), 32'd0);
        Rst_n = 1'b1;

        // LDI 5
        run_instr(16'h1805);
        chk("ldi_sela", 32'(SelA), 32'd1);
        chk("ldi_wracc", 32'(WrAcc), 32'd1);
        chk("ldi_operand", 32'(Operand), 32'd5);
        chk("ldi_pc", 32'(PC), 32'd1);
        step();

        // ADDI 3 ; SUBI 1
        run_instr(16'h2803);
        chk("addi_ctl", 32'({SelA, SelB, Op}), 32'b1011);
        step();
        run_instr(16'h3801);
        chk("subi_ctl", 32'({SelA, SelB, Op}), 32'b1010);
        chk("subi_pc", 32'(PC), 32'd3);
        step();

        // STO 9: single-cycle write
        run_instr(16'h0809);
        chk("sto_wr", 32'({WrRam, WrAcc}), 32'b10);
        chk("sto_operand", 32'(Operand), 32'd9);
        step();
        chk("sto_wr_drop", 32'(WrRam), 32'd0);

        // Undefined opcode 11111 behaves as NOP
        run_instr(16'hF8AA);
        chk("nop_en", 32'({WrAcc, WrRam, RdRam}), 32'd0);
        chk("nop_pc", 32'(PC), 32'd5);
        step();

        // Random non-halting program until PC reaches 2047, then wrap
        guard = 0;
        while (m_pc != 2047 && guard < 3000) begin
            run_instr(rand_no_hlt());
            step();
            guard++;
        end
        chk("wrap_reached_pc", 32'(PC), 32'd2047);
        run_instr(rand_no_hlt());
        chk("wrap_pc", 32'(PC), 32'd0);
        step();

        // Reset in the middle of an ADD execute cycle
        run_instr(16'h2007);
        chk("add_en", 32'({RdRam, WrAcc, SelA, Op}), 32'b11101);
        #2;
        Rst_n = 1'b0;
        #1;
        chk("midreset_en", 32'({WrAcc, RdRam}), 32'd0);
        chk("midreset_pc", 32'(PC), 32'd0);
        step();
        Rst_n = 1'b1;

        // HLT freezes the core until reset
        run_instr(16'h0000);
        chk("hlt_exec_halted", 32'(Halted), 32'd0);
        step();
        chk("hlt_halted", 32'(Halted), 32'd1);
        for (int i = 0; i < 20; i++) begin
            Instr = 16'($urandom);
            step();
        end
        chk("hlt_pc_frozen", 32'(PC), 32'd1);
        chk("hlt_still", 32'(Halted), 32'd1);
        Rst_n = 1'b0;
        #1;
        chk("hlt_reset_pc", 32'(PC), 32'd0);
        chk("hlt_reset_halted", 32'(Halted), 32'd0);
        step();
        Rst_n = 1'b1;
        run_instr(16'h1805);
        chk("post_halt_ldi", 32'({SelA, WrAcc}), 32'b011);
        step();

        // Random stress: any instruction, HLT now and then, resets out of halt
        halt_cnt = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0) Instr = {5'd0, 11'($urandom)};
            else                           Instr = 16'($urandom);
            if (!Rst_n) begin
                Rst_n = 1'b1;
            end else if (halt_cnt > 3 || $urandom_range(0, 49) == 0) begin
                Rst_n = 1'b0;
            end
            halt_cnt = (m_phase == 2) ? halt_cnt + 1 : 0;
            step();
        end
        Rst_n = 1'b1;
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
